// File: rtl/pp_shift_accum_pipe_pkg.sv
// Shared widths and helpers for the 4xN partial-product reduction pipeline.
package mult_pkg;

  localparam int NUM_PP = 4;

  // Product width for a given partial-product (multiplicand) width.
  function automatic int prod_w(input int pp_w);
    return pp_w + NUM_PP;
  endfunction

  // Width of a stage-1 pair sum: pp_a + (pp_b << 1).
  function automatic int pair_w(input int pp_w);
    return pp_w + 2;
  endfunction

endpackage

// File: rtl/pp_shift_accum_pipe_if.sv
// Valid/ready bus between the partial-product generator, the reduction pipe and the consumer.
interface pp_shift_accum_pipe_if
  import mult_pkg::*;
#(
  parameter int PP_W  = 4,
  parameter int CNT_W = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic [PP_W-1:0]           pp0;
  logic [PP_W-1:0]           pp1;
  logic [PP_W-1:0]           pp2;
  logic [PP_W-1:0]           pp3;
  logic                      out_valid;
  logic                      out_ready;
  logic [prod_w(PP_W)-1:0]   product;
  logic [CNT_W-1:0]          prod_cnt;

  modport master (
    output in_valid, pp0, pp1, pp2, pp3, out_ready,
    input  in_ready, out_valid, product, prod_cnt
  );

  modport slave (
    input  in_valid, pp0, pp1, pp2, pp3, out_ready,
    output in_ready, out_valid, product, prod_cnt
  );
endinterface

// File: rtl/pp_shift_accum_pipe_stage.sv
// Generic valid/ready register slice with no skid buffer: accepts whenever empty
// or when its current contents leave in the same cycle.
module pipe_reg_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] din,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] dout
);
  logic load;

  assign in_ready = ~out_valid | out_ready;
  assign load     = in_valid & in_ready;

  // valid follows in_valid whenever the slot is free or draining, so an empty
  // cycle behind a consumed item clears it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
    end else if (in_ready) begin
      out_valid <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (load) begin
      dout <= din;
    end
  end
endmodule

// File: rtl/pp_shift_accum_pipe.sv
// Two-stage shifted-adder tree reducing four partial products to the exact
// product, with valid/ready on both sides and a saturating delivery counter.
module pp_shift_accum_pipe
  import mult_pkg::*;
#(
  parameter int PP_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pp_shift_accum_pipe_if.slave bus
);
  localparam int SW = pair_w(PP_W);
  localparam int PW = prod_w(PP_W);

  logic [SW-1:0]   s01_d, s23_d, s01, s23;
  logic [2*SW-1:0] s1_q;
  logic            s1_valid, s2_in_ready;
  logic [PW-1:0]   product_d;
  logic [CNT_W-1:0] cnt;

  assign s01_d = SW'(bus.pp0) + (SW'(bus.pp1) << 1);
  assign s23_d = SW'(bus.pp2) + (SW'(bus.pp3) << 1);

  pipe_reg_stage #(.W(2*SW)) u_s1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .din       ({s23_d, s01_d}),
    .out_valid (s1_valid),
    .out_ready (s2_in_ready),
    .dout      (s1_q)
  );

  assign s01       = s1_q[SW-1:0];
  assign s23       = s1_q[2*SW-1:SW];
  assign product_d = PW'(s01) + (PW'(s23) << 2);

  // Stage 2 advances exactly when s1_valid & s2_in_ready, which is adv2.
  pipe_reg_stage #(.W(PW)) u_s2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s1_valid),
    .in_ready  (s2_in_ready),
    .din       (product_d),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .dout      (bus.product)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.out_valid && bus.out_ready && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.prod_cnt = cnt;
endmodule

// File: tb/tb_pp_shift_accum_pipe.sv
// Randomized bench: a queue of expected products a*b tracks every accepted input,
// checked at the output of a 16-bit-counter DUT and a 4-bit-counter DUT.
module tb_pp_shift_accum_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pp_shift_accum_pipe_if #(.PP_W(4), .CNT_W(16)) ifm ();
  pp_shift_accum_pipe_if #(.PP_W(4), .CNT_W(4))  ifs ();

  pp_shift_accum_pipe #(.PP_W(4), .CNT_W(16)) dut_m (.clk(clk), .rst_n(rst_n), .bus(ifm));
  pp_shift_accum_pipe #(.PP_W(4), .CNT_W(4))  dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs));

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [7:0]  expq[$];
  int unsigned cnt_m = 0;
  int unsigned cnt_s = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic ordy);
    ifm.in_valid  = v;           ifs.in_valid  = v;
    ifm.pp0 = b[0] ? a : 4'h0;   ifs.pp0 = b[0] ? a : 4'h0;
    ifm.pp1 = b[1] ? a : 4'h0;   ifs.pp1 = b[1] ? a : 4'h0;
    ifm.pp2 = b[2] ? a : 4'h0;   ifs.pp2 = b[2] ? a : 4'h0;
    ifm.pp3 = b[3] ? a : 4'h0;   ifs.pp3 = b[3] ? a : 4'h0;
    ifm.out_ready = ordy;        ifs.out_ready = ordy;
  endtask

  // One clock: drive at negedge, check outputs, then book the handshakes of the next edge.
  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic ordy, output logic acc);
    @(negedge clk);
    drive(v, a, b, ordy);
    #1;
    acc = v & ifm.in_ready;
    chk("in_ready_match", {31'b0, ifs.in_ready}, {31'b0, ifm.in_ready});
    if (ifm.out_valid) begin
      if (expq.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        chk("product", {24'b0, ifm.product}, {24'b0, expq[0]});
        chk("product_s", {24'b0, ifs.product}, {24'b0, expq[0]});
      end
    end
    chk("prod_cnt", {16'b0, ifm.prod_cnt}, cnt_m);
    chk("prod_cnt_s", {28'b0, ifs.prod_cnt}, cnt_s);
    if (ifm.out_valid && ordy && expq.size() != 0) begin
      void'(expq.pop_front());
      if (cnt_m < 32'hFFFF) cnt_m++;
      if (cnt_s < 15) cnt_s++;
    end
    if (acc) expq.push_back(8'({4'b0, a} * {4'b0, b}));
  endtask

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic ordy);
    logic acc;
    int unsigned tries = 0;
    acc = 1'b0;
    while (!acc && tries < 50) begin
      step(1'b1, a, b, ordy, acc);
      tries++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int unsigned tries = 0;
    while ((expq.size() != 0 || ifm.out_valid) && tries < 40) begin
      step(1'b0, 4'h0, 4'h0, 1'b1, acc);
      tries++;
    end
    step(1'b0, 4'h0, 4'h0, 1'b1, acc);
    chk("drain_empty", expq.size(), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    expq.delete();
    cnt_m = 0;
    cnt_s = 0;
    chk("rst_out_valid", {31'b0, ifm.out_valid}, 32'd0);
    chk("rst_product", {24'b0, ifm.product}, 32'd0);
    chk("rst_prod_cnt", {16'b0, ifm.prod_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, ifm.in_ready}, 32'd1);
  endtask

  initial begin
    logic acc, pend, v, ordy;
    logic [3:0] a, b;
    logic [7:0] held;
    drive(1'b0, 4'h0, 4'h0, 1'b0);
    repeat (2) @(negedge clk);

    // Latency: 15*15 appears two clocks after the transfer.
    do_reset();
    step(1'b1, 4'hF, 4'hF, 1'b1, acc);
    chk("lat_acc", {31'b0, acc}, 32'd1);
    step(1'b0, 4'h0, 4'h0, 1'b1, acc);
    chk("lat1_out_valid", {31'b0, ifm.out_valid}, 32'd0);
    step(1'b0, 4'h0, 4'h0, 1'b1, acc);
    chk("lat2_out_valid", {31'b0, ifm.out_valid}, 32'd1);
    chk("lat2_product", {24'b0, ifm.product}, 32'hE1);
    step(1'b0, 4'h0, 4'h0, 1'b1, acc);
    chk("lat_cnt1", {16'b0, ifm.prod_cnt}, 32'd1);

    // 5*3 and the all-zero case.
    send(4'd5, 4'd3, 1'b1);
    send(4'd0, 4'd0, 1'b1);
    drain();

    // Back-to-back streaming.
    do_reset();
    for (int unsigned i = 0; i < 16; i++) begin
      step(1'b1, 4'($urandom), 4'($urandom), 1'b1, acc);
      chk("stream_in_ready", {31'b0, acc}, 32'd1);
    end
    drain();
    chk("stream_cnt16", {16'b0, ifm.prod_cnt}, 32'd16);

    // Backpressure: two inputs fill both stages, the third is refused.
    do_reset();
    send(4'd7, 4'd9, 1'b0);
    send(4'd11, 4'd6, 1'b0);
    step(1'b1, 4'd13, 4'd14, 1'b0, acc);
    chk("bp_in_ready", {31'b0, ifm.in_ready}, 32'd0);
    chk("bp_out_valid", {31'b0, ifm.out_valid}, 32'd1);
    held = ifm.product;
    chk("bp_head", {24'b0, held}, 32'd63);
    for (int unsigned i = 0; i < 3; i++) begin
      step(1'b1, 4'd13, 4'd14, 1'b0, acc);
      chk("bp_hold", {24'b0, ifm.product}, {24'b0, held});
      chk("bp_refused", {31'b0, acc}, 32'd0);
    end
    send(4'd13, 4'd14, 1'b1);
    drain();
    chk("bp_cnt3", {16'b0, ifm.prod_cnt}, 32'd3);

    // Reset with both stages full.
    send(4'd3, 4'd3, 1'b0);
    send(4'd2, 4'd2, 1'b0);
    step(1'b0, 4'h0, 4'h0, 1'b0, acc);
    chk("stall_full", {31'b0, ifm.in_ready}, 32'd0);
    do_reset();
    step(1'b0, 4'h0, 4'h0, 1'b1, acc);
    chk("post_rst_out_valid", {31'b0, ifm.out_valid}, 32'd0);

    // Counter saturation on the 4-bit instance.
    do_reset();
    for (int unsigned i = 0; i < 20; i++) send(4'($urandom), 4'($urandom), 1'b1);
    drain();
    chk("sat_cnt_s", {28'b0, ifs.prod_cnt}, 32'hF);
    chk("sat_cnt_m", {16'b0, ifm.prod_cnt}, 32'd20);

    // Random traffic with random backpressure; refused inputs are held.
    do_reset();
    pend = 1'b0;
    v = 1'b0; a = '0; b = '0;
    for (int unsigned i = 0; i < 400; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        a = 4'($urandom);
        b = 4'($urandom);
      end
      ordy = ($urandom_range(0, 3) != 0);
      step(v, a, b, ordy, acc);
      pend = v & ~acc;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
